// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order using a ping-pong RAM.
// Bin j of a frame whose last sample lands on edge E appears after edge E+2+j.
module fft_bitrev_reorder #(
   parameter int N     = 64,
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             idata_en,
   input  logic [WIDTH-1:0] idata_r,
   input  logic [WIDTH-1:0] idata_i,
   output logic             odata_en,
   output logic [WIDTH-1:0] odata_r,
   output logic [WIDTH-1:0] odata_i
);
   localparam int LOG_N = $clog2(N);
   localparam int DW    = 2 * WIDTH;

   typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

   logic [LOG_N-1:0] in_count_q, in_count_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_start_q, rd_start_d;
   rd_state_t        rd_state_q, rd_state_d;
   logic [LOG_N-1:0] rd_count_q, rd_count_d;
   logic             rd_bank_q, rd_bank_d;
   logic             rd_valid_q;
   logic             rd_en;
   logic             frame_done;
   logic [LOG_N-1:0] wr_addr;
   logic [DW-1:0]    rdata_q;
   logic [DW-1:0]    mem [0:2*N-1];

   genvar gi;
   generate
      for (gi = 0; gi < LOG_N; gi++) begin : g_bitrev
         assign wr_addr[gi] = in_count_q[LOG_N-1-gi];
      end
   endgenerate

   // A dropped enable restarts the count, so a partial frame is simply overwritten.
   assign frame_done = idata_en && (in_count_q == LOG_N'(N - 1));
   assign in_count_d = idata_en ? in_count_q + LOG_N'(1) : '0;
   assign wr_bank_d  = wr_bank_q ^ frame_done;
   assign rd_start_d = frame_done;
   assign rd_en      = (rd_state_q == RD_RUN);

   always_comb begin
      rd_state_d = rd_state_q;
      rd_count_d = rd_count_q;
      rd_bank_d  = rd_bank_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (rd_start_q) begin
               rd_state_d = RD_RUN;
               rd_count_d = '0;
               rd_bank_d  = ~wr_bank_q;
            end
         end
         RD_RUN: begin
            if (rd_count_q == LOG_N'(N - 1)) begin
               rd_count_d = '0;
               // A frame completing exactly now chains on without a gap.
               if (rd_start_q) begin
                  rd_bank_d = ~wr_bank_q;
               end else begin
                  rd_state_d = RD_IDLE;
               end
            end else begin
               rd_count_d = rd_count_q + LOG_N'(1);
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_count_q <= '0;
         wr_bank_q  <= 1'b0;
         rd_start_q <= 1'b0;
         rd_state_q <= RD_IDLE;
         rd_count_q <= '0;
         rd_bank_q  <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         in_count_q <= in_count_d;
         wr_bank_q  <= wr_bank_d;
         rd_start_q <= rd_start_d;
         rd_state_q <= rd_state_d;
         rd_count_q <= rd_count_d;
         rd_bank_q  <= rd_bank_d;
         rd_valid_q <= rd_en;
      end
   end

   always_ff @(posedge clock) begin
      if (idata_en) begin
         mem[{wr_bank_q, wr_addr}] <= {idata_r, idata_i};
      end
      if (rd_en) begin
         rdata_q <= mem[{rd_bank_q, rd_count_q}];
      end
   end

   // Gating with the async-reset valid zeroes the outputs the moment reset rises.
   assign odata_en = rd_valid_q;
   assign odata_r  = rd_valid_q ? rdata_q[DW-1:WIDTH] : '0;
   assign odata_i  = rd_valid_q ? rdata_q[WIDTH-1:0]  : '0;

endmodule
